// File: rtl/alu_issue_if.sv
// Handshake and datapath bundle between the instruction source / ALU / memory
// and the ALU issue controller.
interface alu_issue_if #(
  parameter int RETIRE_W = 16
);
  logic                instr_valid;
  logic [31:0]         instr;
  logic                instr_ready;
  logic [4:0]          rs1_addr;
  logic [4:0]          rs2_addr;
  logic [3:0]          operation_code;
  logic [1:0]          alusrc;
  logic [31:0]         immediate;
  logic                issue_valid;
  logic                mem_read;
  logic                mem_write;
  logic [31:0]         alu_result;
  logic [31:0]         mem_rdata;
  logic                wb_en;
  logic [4:0]          wb_addr;
  logic [31:0]         wb_data;
  logic                illegal_instr;
  logic [RETIRE_W-1:0] retired;

  // Upstream side: instruction source, ALU and data memory.
  modport master (
    output instr_valid, instr, alu_result, mem_rdata,
    input  instr_ready, rs1_addr, rs2_addr, operation_code, alusrc, immediate,
           issue_valid, mem_read, mem_write, wb_en, wb_addr, wb_data,
           illegal_instr, retired
  );

  modport slave (
    input  instr_valid, instr, alu_result, mem_rdata,
    output instr_ready, rs1_addr, rs2_addr, operation_code, alusrc, immediate,
           issue_valid, mem_read, mem_write, wb_en, wb_addr, wb_data,
           illegal_instr, retired
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Four-state issue controller for a small RV32 subset: accepts one instruction,
// decodes it, issues ALU/memory controls for one cycle, then writes back.
module alu_issue_ctrl #(
  parameter int RETIRE_W = 16
) (
  input  logic      clk,
  input  logic      reset,
  alu_issue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DECODE, ISSUE, WB} state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] op;
    logic [1:0] alusrc;
    logic       writes_rd;
    logic       is_load;
    logic       is_store;
  } dec_t;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b1101;

  function automatic dec_t decode(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [6:0] f7);
    dec_t d;
    d = '0;
    case (opc)
      7'b0110011: begin
        d.writes_rd = 1'b1;
        if (f3 == 3'b000) begin
          case (f7)
            7'b0000000: begin d.legal = 1'b1; d.op = OP_ADD; end
            7'b0100000: begin d.legal = 1'b1; d.op = OP_SUB; end
            7'b0000001: begin d.legal = 1'b1; d.op = OP_MUL; end
            default: ;
          endcase
        end else if (f7 == 7'b0000000) begin
          case (f3)
            3'b111: begin d.legal = 1'b1; d.op = OP_AND; end
            3'b110: begin d.legal = 1'b1; d.op = OP_OR;  end
            3'b001: begin d.legal = 1'b1; d.op = OP_SLL; end
            default: ;
          endcase
        end
      end
      7'b0010011: begin
        d.writes_rd = 1'b1;
        d.alusrc    = 2'b01;
        case (f3)
          3'b000: begin d.legal = 1'b1; d.op = OP_ADD; end
          3'b111: begin d.legal = 1'b1; d.op = OP_AND; end
          3'b110: begin d.legal = 1'b1; d.op = OP_OR;  end
          3'b001: begin d.legal = (f7 == 7'b0000000); d.op = OP_SLL; end
          default: ;
        endcase
      end
      7'b0000011: begin
        d.legal     = (f3 == 3'b010);
        d.op        = OP_ADD;
        d.alusrc    = 2'b01;
        d.writes_rd = 1'b1;
        d.is_load   = 1'b1;
      end
      7'b0100011: begin
        d.legal    = (f3 == 3'b010);
        d.op       = OP_ADD;
        d.alusrc   = 2'b01;
        d.is_store = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

  state_t              state;
  dec_t                dec_in;
  dec_t                dec_p0;
  logic                instr_ready_q;
  logic [31:0]         immediate_q;
  logic [4:0]          rs1_q;
  logic [4:0]          rs2_q;
  logic [4:0]          rd_p1;
  logic                writes_rd_p1;
  logic                is_load_p1;
  logic [3:0]          op_q;
  logic [1:0]          alusrc_q;
  logic                issue_valid_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic                wb_en_q;
  logic [31:0]         wb_data_q;
  logic                illegal_q;
  logic [RETIRE_W-1:0] retired_q;

  // Pre-decode the incoming word so the illegal pulse lines up with DECODE.
  assign dec_in = decode(bus.instr[6:0], bus.instr[14:12], bus.instr[31:25]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      dec_p0        <= '0;
      instr_ready_q <= 1'b1;
      immediate_q   <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_p1         <= '0;
      writes_rd_p1  <= 1'b0;
      is_load_p1    <= 1'b0;
      op_q          <= '0;
      alusrc_q      <= '0;
      issue_valid_q <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      wb_en_q       <= 1'b0;
      wb_data_q     <= '0;
      illegal_q     <= 1'b0;
      retired_q     <= '0;
    end else begin
      illegal_q     <= 1'b0;
      issue_valid_q <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      wb_en_q       <= 1'b0;
      case (state)
        // p0: accept and latch the raw word
        IDLE: begin
          if (bus.instr_valid) begin
            immediate_q   <= bus.instr;
            dec_p0        <= dec_in;
            illegal_q     <= ~dec_in.legal;
            instr_ready_q <= 1'b0;
            state         <= DECODE;
          end
        end
        // p1: register operand addresses and ALU controls
        DECODE: begin
          rs1_q <= immediate_q[19:15];
          rs2_q <= immediate_q[24:20];
          rd_p1 <= immediate_q[11:7];
          if (dec_p0.legal) begin
            op_q          <= dec_p0.op;
            alusrc_q      <= dec_p0.alusrc;
            writes_rd_p1  <= dec_p0.writes_rd;
            is_load_p1    <= dec_p0.is_load;
            issue_valid_q <= 1'b1;
            mem_read_q    <= dec_p0.is_load;
            mem_write_q   <= dec_p0.is_store;
            state         <= ISSUE;
          end else begin
            instr_ready_q <= 1'b1;
            state         <= IDLE;
          end
        end
        // p2: capture the result; retired is visible during WB
        ISSUE: begin
          wb_data_q <= is_load_p1 ? bus.mem_rdata : bus.alu_result;
          wb_en_q   <= writes_rd_p1 && (rd_p1 != 5'd0);
          retired_q <= retired_q + 1'b1;
          state     <= WB;
        end
        WB: begin
          instr_ready_q <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.instr_ready    = instr_ready_q;
  assign bus.rs1_addr       = rs1_q;
  assign bus.rs2_addr       = rs2_q;
  assign bus.operation_code = op_q;
  assign bus.alusrc         = alusrc_q;
  assign bus.immediate      = immediate_q;
  assign bus.issue_valid    = issue_valid_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.wb_en          = wb_en_q;
  assign bus.wb_addr        = rd_p1;
  assign bus.wb_data        = wb_data_q;
  assign bus.illegal_instr  = illegal_q;
  assign bus.retired        = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; a second instance with a 2-bit retired
// counter runs in lockstep so counter wrap is reachable in a few instructions.
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_if #(.RETIRE_W(16)) bus();
  alu_issue_if #(.RETIRE_W(2))  bus2();

  alu_issue_ctrl #(.RETIRE_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
  alu_issue_ctrl #(.RETIRE_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

  assign bus2.instr_valid = bus.instr_valid;
  assign bus2.instr       = bus.instr;
  assign bus2.alu_result  = bus.alu_result;
  assign bus2.mem_rdata   = bus.mem_rdata;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] exp_ret = 16'd0;

  localparam logic [31:0] W_ADD  = 32'h002081B3;
  localparam logic [31:0] W_SUB  = 32'h407302B3;
  localparam logic [31:0] W_SW   = 32'h0020A423;
  localparam logic [31:0] W_ADDI = 32'h00500013;
  localparam logic [31:0] W_LW   = 32'h00012183;
  localparam logic [31:0] W_BAD  = 32'hFFFFFFFF;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready, presents w for one cycle; returns in cycle T+1.
  task automatic accept(input logic [31:0] w);
    for (int i = 0; i < 20 && bus.instr_ready !== 1'b1; i++) step();
    n_cmp++;
    if (bus.instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready_timeout got %b want 1", bus.instr_ready);
    end
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    step();
    bus.instr_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.alu_result = '0;
    bus.mem_rdata = '0;
    step();
    step();
    n_cmp++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", bus.instr_ready); end
    n_cmp++; if (bus.operation_code !== 4'b0000) begin n_fail++; $display("FAIL rst_op got %b want 0000", bus.operation_code); end
    n_cmp++; if (bus.alusrc !== 2'b00) begin n_fail++; $display("FAIL rst_alusrc got %b want 00", bus.alusrc); end
    n_cmp++; if (bus.immediate !== 32'd0) begin n_fail++; $display("FAIL rst_imm got %h want 0", bus.immediate); end
    n_cmp++; if ({bus.rs1_addr, bus.rs2_addr, bus.wb_addr} !== 15'd0) begin n_fail++; $display("FAIL rst_addrs got %h want 0", {bus.rs1_addr, bus.rs2_addr, bus.wb_addr}); end
    n_cmp++; if (bus.wb_data !== 32'd0) begin n_fail++; $display("FAIL rst_wb_data got %h want 0", bus.wb_data); end
    n_cmp++; if ({bus.issue_valid, bus.mem_read, bus.mem_write, bus.wb_en, bus.illegal_instr} !== 5'd0) begin n_fail++; $display("FAIL rst_strobes got %b want 00000", {bus.issue_valid, bus.mem_read, bus.mem_write, bus.wb_en, bus.illegal_instr}); end
    n_cmp++; if (bus.retired !== 16'd0) begin n_fail++; $display("FAIL rst_retired got %h want 0", bus.retired); end
    reset = 1'b0;
    step();
    n_cmp++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got %b want 1", bus.instr_ready); end
  endtask

  task automatic test_add;
    bus.alu_result = 32'd7;
    accept(W_ADD);
    n_cmp++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL add_t1_ready got %b want 0", bus.instr_ready); end
    n_cmp++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL add_t1_issue got %b want 0", bus.issue_valid); end
    n_cmp++; if (bus.immediate !== W_ADD) begin n_fail++; $display("FAIL add_t1_imm got %h want %h", bus.immediate, W_ADD); end
    step();
    n_cmp++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL add_t2_issue got %b want 1", bus.issue_valid); end
    n_cmp++; if (bus.operation_code !== 4'b0010) begin n_fail++; $display("FAIL add_t2_op got %b want 0010", bus.operation_code); end
    n_cmp++; if (bus.alusrc !== 2'b00) begin n_fail++; $display("FAIL add_t2_alusrc got %b want 00", bus.alusrc); end
    n_cmp++; if (bus.rs1_addr !== 5'd1 || bus.rs2_addr !== 5'd2) begin n_fail++; $display("FAIL add_t2_rs got %0d/%0d want 1/2", bus.rs1_addr, bus.rs2_addr); end
    n_cmp++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL add_t2_strobes got %b%b%b want 000", bus.mem_read, bus.mem_write, bus.wb_en); end
    step();
    exp_ret++;
    n_cmp++; if (bus.wb_en !== 1'b1) begin n_fail++; $display("FAIL add_t3_wb_en got %b want 1", bus.wb_en); end
    n_cmp++; if (bus.wb_addr !== 5'd3) begin n_fail++; $display("FAIL add_t3_wb_addr got %0d want 3", bus.wb_addr); end
    n_cmp++; if (bus.wb_data !== 32'd7) begin n_fail++; $display("FAIL add_t3_wb_data got %h want 7", bus.wb_data); end
    n_cmp++; if (bus.retired !== exp_ret) begin n_fail++; $display("FAIL add_t3_retired got %h want %h", bus.retired, exp_ret); end
    n_cmp++; if (bus.issue_valid !== 1'b0 || bus.operation_code !== 4'b0010) begin n_fail++; $display("FAIL add_t3_hold got %b/%b want 0/0010", bus.issue_valid, bus.operation_code); end
    step();
    n_cmp++; if (bus.instr_ready !== 1'b1 || bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL add_t4_idle got %b/%b want 1/0", bus.instr_ready, bus.wb_en); end
  endtask

  task automatic test_back_to_back;
    bus.alu_result = 32'h55;
    for (int i = 0; i < 20 && bus.instr_ready !== 1'b1; i++) step();
    bus.instr_valid = 1'b1;
    bus.instr = W_SUB;
    step();
    bus.instr = W_ADD;
    n_cmp++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_t1_ready got %b want 0", bus.instr_ready); end
    step();
    n_cmp++; if (bus.operation_code !== 4'b0110) begin n_fail++; $display("FAIL b2b_t2_op got %b want 0110", bus.operation_code); end
    n_cmp++; if (bus.rs1_addr !== 5'd6 || bus.rs2_addr !== 5'd7) begin n_fail++; $display("FAIL b2b_t2_rs got %0d/%0d want 6/7", bus.rs1_addr, bus.rs2_addr); end
    n_cmp++; if (bus.immediate !== W_SUB) begin n_fail++; $display("FAIL b2b_t2_imm got %h want %h", bus.immediate, W_SUB); end
    step();
    n_cmp++; if (bus.wb_en !== 1'b1 || bus.wb_addr !== 5'd5 || bus.wb_data !== 32'h55) begin n_fail++; $display("FAIL b2b_t3_wb got %b/%0d/%h want 1/5/55", bus.wb_en, bus.wb_addr, bus.wb_data); end
    n_cmp++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_t3_ready got %b want 0", bus.instr_ready); end
    step();
    n_cmp++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_t4_ready got %b want 1", bus.instr_ready); end
    step();
    bus.instr_valid = 1'b0;
    n_cmp++; if (bus.instr_ready !== 1'b0 || bus.immediate !== W_ADD) begin n_fail++; $display("FAIL b2b_t5_accept got %b/%h want 0/%h", bus.instr_ready, bus.immediate, W_ADD); end
    step();
    n_cmp++; if (bus.issue_valid !== 1'b1 || bus.operation_code !== 4'b0010) begin n_fail++; $display("FAIL b2b_t6_issue got %b/%b want 1/0010", bus.issue_valid, bus.operation_code); end
    step();
    step();
    exp_ret = exp_ret + 16'd2;
    n_cmp++; if (bus.retired !== exp_ret) begin n_fail++; $display("FAIL b2b_retired got %h want %h", bus.retired, exp_ret); end
  endtask

  task automatic test_sw;
    bus.alu_result = 32'h10;
    accept(W_SW);
    step();
    n_cmp++; if (bus.mem_write !== 1'b1 || bus.issue_valid !== 1'b1 || bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL sw_t2_strobes got w%b i%b r%b want 1/1/0", bus.mem_write, bus.issue_valid, bus.mem_read); end
    n_cmp++; if (bus.operation_code !== 4'b0010 || bus.alusrc !== 2'b01) begin n_fail++; $display("FAIL sw_t2_ctrl got %b/%b want 0010/01", bus.operation_code, bus.alusrc); end
    step();
    exp_ret++;
    n_cmp++; if (bus.wb_en !== 1'b0 || bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL sw_t3_strobes got %b/%b want 0/0", bus.wb_en, bus.mem_write); end
    n_cmp++; if (bus.retired !== exp_ret) begin n_fail++; $display("FAIL sw_t3_retired got %h want %h", bus.retired, exp_ret); end
    step();
  endtask

  task automatic test_addi_x0;
    accept(W_ADDI);
    step();
    n_cmp++; if (bus.alusrc !== 2'b01 || bus.operation_code !== 4'b0010) begin n_fail++; $display("FAIL addi_t2_ctrl got %b/%b want 01/0010", bus.alusrc, bus.operation_code); end
    step();
    exp_ret++;
    n_cmp++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL addi_t3_wb_en got %b want 0", bus.wb_en); end
    n_cmp++; if (bus.retired !== exp_ret) begin n_fail++; $display("FAIL addi_t3_retired got %h want %h", bus.retired, exp_ret); end
    step();
  endtask

  task automatic test_illegal;
    accept(W_BAD);
    n_cmp++; if (bus.illegal_instr !== 1'b1) begin n_fail++; $display("FAIL ill_t1_pulse got %b want 1", bus.illegal_instr); end
    step();
    n_cmp++; if (bus.illegal_instr !== 1'b0 || bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL ill_t2_quiet got %b/%b want 0/0", bus.illegal_instr, bus.issue_valid); end
    n_cmp++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL ill_t2_ready got %b want 1", bus.instr_ready); end
    step();
    n_cmp++; if (bus.wb_en !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL ill_t3_strobes got %b%b%b want 000", bus.wb_en, bus.mem_read, bus.mem_write); end
    n_cmp++; if (bus.retired !== exp_ret) begin n_fail++; $display("FAIL ill_retired got %h want %h", bus.retired, exp_ret); end
  endtask

  task automatic test_lw;
    bus.mem_rdata = 32'hDEADBEEF;
    bus.alu_result = 32'h1234;
    accept(W_LW);
    step();
    n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.alusrc !== 2'b01) begin n_fail++; $display("FAIL lw_t2 got r%b w%b s%b want 1/0/01", bus.mem_read, bus.mem_write, bus.alusrc); end
    step();
    exp_ret++;
    n_cmp++; if (bus.wb_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_t3_wb_data got %h want deadbeef", bus.wb_data); end
    n_cmp++; if (bus.wb_en !== 1'b1 || bus.wb_addr !== 5'd3 || bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL lw_t3_wb got %b/%0d/%b want 1/3/0", bus.wb_en, bus.wb_addr, bus.mem_read); end
    step();
  endtask

  task automatic test_reset_in_issue;
    bus.alu_result = 32'h99;
    accept(W_ADD);
    step();
    n_cmp++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL rii_in_issue got %b want 1", bus.issue_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_ret = 16'd0;
    n_cmp++; if (bus.wb_en !== 1'b0 || bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL rii_after got wb%b rdy%b want 0/1", bus.wb_en, bus.instr_ready); end
    n_cmp++; if (bus.retired !== 16'd0) begin n_fail++; $display("FAIL rii_retired got %h want 0", bus.retired); end
    step();
    n_cmp++; if (bus.wb_en !== 1'b0 || bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL rii_next got %b/%b want 0/0", bus.wb_en, bus.issue_valid); end
    // Reset wins over a simultaneous valid instruction.
    reset = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr = W_ADD;
    step();
    reset = 1'b0;
    bus.instr_valid = 1'b0;
    n_cmp++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL rprio_ready got %b want 1", bus.instr_ready); end
    step();
    n_cmp++; if (bus.issue_valid !== 1'b0 || bus.instr_ready !== 1'b1 || bus.immediate !== 32'd0) begin n_fail++; $display("FAIL rprio_idle got %b/%b/%h want 0/1/0", bus.issue_valid, bus.instr_ready, bus.immediate); end
  endtask

  task automatic test_wrap;
    logic [1:0] exp2;
    exp2 = 2'd0;
    for (int i = 0; i < 4; i++) begin
      accept(W_ADD);
      step();
      step();
      exp2++;
      exp_ret++;
      n_cmp++; if (bus2.retired !== exp2) begin n_fail++; $display("FAIL wrap_small_%0d got %0d want %0d", i, bus2.retired, exp2); end
      n_cmp++; if (bus.retired !== exp_ret) begin n_fail++; $display("FAIL wrap_main_%0d got %h want %h", i, bus.retired, exp_ret); end
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.alu_result = '0;
    bus.mem_rdata = '0;
    test_reset();
    test_add();
    test_back_to_back();
    test_sw();
    test_addi_x0();
    test_illegal();
    test_lw();
    test_reset_in_issue();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: RETIRE_W, 16, width of the retired-instruction counter.
REQ-002 clk  in  1  rising-edge clock; all state updates on this edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 instr_valid  in  1  upstream holds a valid instruction on instr.
REQ-005 instr  in  32  RV32 instruction word.
REQ-006 instr_ready  out  1  block can accept an instruction.
REQ-007 rs1_addr, rs2_addr  out  5 each  register-file read addresses.
REQ-008 operation_code  out  4  ALU op: ADD 0010, SUB 0110, MUL 1010, AND 0000, OR 0001, SLL 1101.
REQ-009 alusrc  out  2  00 = register operand, 01 = immediate.
REQ-010 immediate  out  32  latched raw instruction word; the ALU extracts the immediate from it.
REQ-011 issue_valid  out  1  ALU controls valid this cycle.
REQ-012 mem_read, mem_write  out  1 each  LW / SW strobes.
REQ-013 alu_result  in  32  combinational ALU result.
REQ-014 mem_rdata  in  32  load data, valid in the ISSUE cycle.
REQ-015 wb_en  out  1  register-file write strobe.
REQ-016 wb_addr  out  5  destination register.
REQ-017 wb_data  out  32  write-back data.
REQ-018 illegal_instr  out  1  one-cycle pulse on an unsupported encoding.
REQ-019 retired  out  RETIRE_W  count of completed legal instructions.

Function
REQ-020 FSM states SHALL be IDLE, DECODE, ISSUE and WB.
- IDLE -> DECODE on instr_valid && instr_ready.
- DECODE -> ISSUE when legal; DECODE -> IDLE when illegal.
- ISSUE -> WB.
- WB -> IDLE.
REQ-021 instr_ready SHALL be 1 only in IDLE; instr SHALL be latched on the accepting edge and ignored in every other state.
REQ-022 DECODE SHALL register rs1_addr = instr[19:15], rs2_addr = instr[24:20], rd = instr[11:7], operation_code, alusrc and an internal writes-rd flag.
REQ-023 Legal decode table (anything else is illegal):
- opcode 0110011, funct3 000: funct7 0000000 -> ADD; funct7 0100000 -> SUB; funct7 0000001 -> MUL.
- opcode 0110011, funct7 0000000: funct3 111 -> AND; funct3 110 -> OR; funct3 001 -> SLL. All R-type forms use alusrc 00.
- opcode 0010011, alusrc 01: funct3 000 -> ADD (ADDI), 111 -> AND, 110 -> OR; funct3 001 with funct7 0000000 -> SLL (SLLI).
- opcode 0000011, funct3 010: LW -> ADD, alusrc 01, mem_read.
- opcode 0100011, funct3 010: SW -> ADD, alusrc 01, mem_write, no rd write.
REQ-024 issue_valid, mem_read and mem_write SHALL each be high for exactly the single ISSUE cycle; operation_code, alusrc and immediate SHALL hold stable from ISSUE through WB.
REQ-025 At the ISSUE-ending edge, the block SHALL capture mem_rdata for LW and alu_result otherwise into wb_data.
REQ-026 In WB, wb_en SHALL be 1 iff the instruction writes rd and rd != 0; wb_addr = rd.
REQ-027 Latency from accept edge T:
- ISSUE occupies cycle T+2.
- WB occupies cycle T+3.
- instr_ready returns to 1 in cycle T+4.
- Throughput is one instruction per 4 cycles.
REQ-028 retired SHALL increment by 1 in WB for every legal instruction, including SW and rd = 0, and SHALL wrap from all-ones to 0.
REQ-029 An illegal instruction SHALL pulse illegal_instr for the DECODE cycle, produce no issue_valid, mem or wb strobe, and leave retired unchanged.
REQ-030 Outside their active states, wb_en, issue_valid, mem_read, mem_write and illegal_instr SHALL be 0.

Reset
REQ-031 On reset:
- State = IDLE.
- instr_ready = 1 in the following cycle.
- operation_code = 0000, alusrc = 00, immediate = 0, rs1/rs2/wb_addr = 0, wb_data = 0.
- All strobes = 0 and retired = 0.
REQ-032 Reset asserted in any state SHALL discard the in-flight instruction with no subsequent wb_en, mem or issue strobe; reset SHALL take priority over a simultaneous instr_valid.

Verification
REQ-033 0x002081B3 (ADD x3,x1,x2) accepted at T, alu_result = 7 -> T+2: issue_valid = 1, op 0010, alusrc 00, rs1 = 1, rs2 = 2; T+3: wb_en = 1, wb_addr = 3, wb_data = 7; retired = 1.
REQ-034 0x407302B3 (SUB x5,x6,x7) -> op 0110, rs1 = 6, rs2 = 7, wb_addr = 5; back-to-back instr_valid is accepted only at T+4.
REQ-035 0x0020A423 (SW x2,8(x1)) -> op 0010, alusrc 01, mem_write pulse at T+2, no wb_en, retired increments.
REQ-036 0x00500013 (ADDI x0,x0,5) -> wb_en stays 0; 0xFFFFFFFF -> illegal_instr pulse at T+1, no issue_valid, retired unchanged.
REQ-037 0x00012183 (LW x3,0(x2)) with mem_rdata = 0xDEADBEEF -> mem_read at T+2, wb_data = 0xDEADBEEF at T+3.
REQ-038 Reset asserted in ISSUE -> no wb_en follows, instr_ready = 1 next cycle; preload retired = 0xFFFF and retire one instruction -> retired = 0x0000.
